// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: opcodes, next-address select codes,
// branch-condition codes and the sequencer state encoding.
package fetch_sequencer_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned BRTYPE_W = 4;
  localparam int unsigned PCSEL_W  = 2;
  localparam int unsigned BLABEL_W = 16;
  localparam int unsigned JLABEL_W = 26;

  localparam logic [OP_W-1:0] OP_BR   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL  = 6'b000011;
  localparam logic [OP_W-1:0] OP_JR   = 6'b000101;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  localparam logic [PCSEL_W-1:0] PCSEL_SEQ = 2'd0;
  localparam logic [PCSEL_W-1:0] PCSEL_JMP = 2'd1;
  localparam logic [PCSEL_W-1:0] PCSEL_REG = 2'd2;

  localparam logic [BRTYPE_W-1:0] BT_NONE   = 4'd0;
  localparam logic [BRTYPE_W-1:0] BT_SEQ    = 4'd1;
  localparam logic [BRTYPE_W-1:0] BT_EQ     = 4'd2;
  localparam logic [BRTYPE_W-1:0] BT_NE     = 4'd3;
  localparam logic [BRTYPE_W-1:0] BT_LT     = 4'd4;
  localparam logic [BRTYPE_W-1:0] BT_GE     = 4'd5;
  localparam logic [BRTYPE_W-1:0] BT_LTU    = 4'd6;
  localparam logic [BRTYPE_W-1:0] BT_GEU    = 4'd7;
  localparam logic [BRTYPE_W-1:0] BT_ALWAYS = 4'd8;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_UPDATE = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_decode_ctl.sv
// Combinational opcode decode into the next-address control fields.
module fetch_decode_ctl
  import fetch_sequencer_pkg::*;
(
  input  logic [31:0] instr_word,
  output logic [3:0]  brtype_c,
  output logic [1:0]  pc_sel_c,
  output logic [15:0] branch_label_c,
  output logic [25:0] jmp_label_c,
  output logic        is_jal_c,
  output logic        is_halt_c
);

  logic [OP_W-1:0] opcode;

  assign opcode = instr_word[31:26];

  always_comb begin
    brtype_c       = BT_NONE;
    pc_sel_c       = PCSEL_SEQ;
    branch_label_c = '0;
    jmp_label_c    = '0;
    is_jal_c       = 1'b0;
    is_halt_c      = 1'b0;
    case (opcode)
      OP_BR: begin
        brtype_c       = instr_word[25:22];
        branch_label_c = instr_word[15:0];
      end
      OP_J: begin
        pc_sel_c    = PCSEL_JMP;
        jmp_label_c = instr_word[25:0];
      end
      OP_JAL: begin
        pc_sel_c    = PCSEL_JMP;
        jmp_label_c = instr_word[25:0];
        is_jal_c    = 1'b1;
      end
      OP_JR: begin
        pc_sel_c = PCSEL_REG;
      end
      OP_HALT: begin
        is_halt_c = 1'b1;
      end
      // Plain instructions fall through to pc+1 via a zero branch offset.
      default: begin
        brtype_c = BT_SEQ;
      end
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: owns the PC, runs the imem handshake with an ack
// timeout, latches decoded control-flow fields and issues the JAL link write.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        ex_done,
  output logic [3:0]  brtype,
  output logic [1:0]  pc_sel,
  output logic [15:0] branch_label,
  output logic [25:0] jmp_label,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        halted,
  output logic        fetch_err
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       instr_q, instr_d;
  logic [3:0]        brtype_q, brtype_d;
  logic [1:0]        pc_sel_q, pc_sel_d;
  logic [15:0]       branch_label_q, branch_label_d;
  logic [25:0]       jmp_label_q, jmp_label_d;
  logic              is_jal_q, is_jal_d;
  logic              is_halt_q, is_halt_d;
  logic              imem_req_q, imem_req_d;
  logic              instr_valid_q, instr_valid_d;
  logic              link_we_q, link_we_d;
  logic [31:0]       link_data_q, link_data_d;
  logic              halted_q, halted_d;
  logic              fetch_err_q, fetch_err_d;

  logic [3:0]  dec_brtype;
  logic [1:0]  dec_pc_sel;
  logic [15:0] dec_branch_label;
  logic [25:0] dec_jmp_label;
  logic        dec_is_jal;
  logic        dec_is_halt;

  // Decode the incoming word so the controls register together with instr.
  fetch_decode_ctl u_decode (
    .instr_word     (imem_rdata),
    .brtype_c       (dec_brtype),
    .pc_sel_c       (dec_pc_sel),
    .branch_label_c (dec_branch_label),
    .jmp_label_c    (dec_jmp_label),
    .is_jal_c       (dec_is_jal),
    .is_halt_c      (dec_is_halt)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cnt_d          = cnt_q;
    instr_d        = instr_q;
    brtype_d       = brtype_q;
    pc_sel_d       = pc_sel_q;
    branch_label_d = branch_label_q;
    jmp_label_d    = jmp_label_q;
    is_jal_d       = is_jal_q;
    is_halt_d      = is_halt_q;
    fetch_err_d    = fetch_err_q;

    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d        = imem_rdata;
          brtype_d       = dec_brtype;
          pc_sel_d       = dec_pc_sel;
          branch_label_d = dec_branch_label;
          jmp_label_d    = dec_jmp_label;
          is_jal_d       = dec_is_jal;
          is_halt_d      = dec_is_halt;
          cnt_d          = '0;
          state_d        = ST_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          fetch_err_d = 1'b1;
          state_d     = ST_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        if (is_halt_q) begin
          state_d = ST_HALT;
        end else if (ex_done) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        pc_d    = next_pc;
        cnt_d   = '0;
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    // Strobes are registered against the state being entered.
    imem_req_d    = (state_d == ST_FETCH);
    instr_valid_d = (state_d == ST_DECODE);
    halted_d      = (state_d == ST_HALT);
    link_we_d     = (state_d == ST_UPDATE) && is_jal_q;
    link_data_d   = link_we_d ? (pc_q + 32'd1) : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_FETCH;
      pc_q           <= RESET_PC;
      cnt_q          <= '0;
      instr_q        <= '0;
      brtype_q       <= '0;
      pc_sel_q       <= '0;
      branch_label_q <= '0;
      jmp_label_q    <= '0;
      is_jal_q       <= 1'b0;
      is_halt_q      <= 1'b0;
      imem_req_q     <= 1'b1;
      instr_valid_q  <= 1'b0;
      link_we_q      <= 1'b0;
      link_data_q    <= '0;
      halted_q       <= 1'b0;
      fetch_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      cnt_q          <= cnt_d;
      instr_q        <= instr_d;
      brtype_q       <= brtype_d;
      pc_sel_q       <= pc_sel_d;
      branch_label_q <= branch_label_d;
      jmp_label_q    <= jmp_label_d;
      is_jal_q       <= is_jal_d;
      is_halt_q      <= is_halt_d;
      imem_req_q     <= imem_req_d;
      instr_valid_q  <= instr_valid_d;
      link_we_q      <= link_we_d;
      link_data_q    <= link_data_d;
      halted_q       <= halted_d;
      fetch_err_q    <= fetch_err_d;
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign brtype       = brtype_q;
  assign pc_sel       = pc_sel_q;
  assign branch_label = branch_label_q;
  assign jmp_label    = jmp_label_q;
  assign link_we      = link_we_q;
  assign link_data    = link_data_q;
  assign halted       = halted_q;
  assign fetch_err    = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP_W  = 32'h0000_0000;
  localparam logic [31:0] BR_W   = 32'h1040_0005;
  localparam logic [31:0] JAL_W  = 32'h0C00_0040;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ex_done;
  logic [3:0]  brtype;
  logic [1:0]  pc_sel;
  logic [15:0] branch_label;
  logic [25:0] jmp_label;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        link_we;
  logic [31:0] link_data;
  logic        halted;
  logic        fetch_err;

  logic        use_inc;
  logic [31:0] next_pc_fix;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Next-address stand-in: either pc+1 or a fixed target.
  always_comb next_pc = use_inc ? (pc + 32'd1) : next_pc_fix;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .ex_done(ex_done),
    .brtype(brtype), .pc_sel(pc_sel), .branch_label(branch_label), .jmp_label(jmp_label),
    .pc(pc), .next_pc(next_pc), .link_we(link_we), .link_data(link_data),
    .halted(halted), .fetch_err(fetch_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // Reset, then run one plain instruction whose next address is target.
  task automatic goto_pc(input logic [31:0] target);
    do_reset();
    imem_ack    = 1'b1;
    imem_rdata  = NOP_W;
    ex_done     = 1'b1;
    use_inc     = 1'b0;
    next_pc_fix = target;
    repeat (3) step();
  endtask

  task automatic test_reset();
    imem_ack = 1'b0; ex_done = 1'b0; imem_rdata = NOP_W; use_inc = 1'b1; next_pc_fix = '0;
    do_reset();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_req got=%b exp=1", imem_req); end
    total++;
    if ({instr_valid, link_we, halted, fetch_err} !== 4'b0 || instr !== 32'h0 || brtype !== 4'h0 ||
        pc_sel !== 2'd0 || branch_label !== 16'h0 || jmp_label !== 26'h0 || link_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_outs got v=%b lw=%b h=%b fe=%b instr=%h bt=%h ps=%h bl=%h jl=%h ld=%h exp all zero",
               instr_valid, link_we, halted, fetch_err, instr, brtype, pc_sel, branch_label, jmp_label, link_data);
    end
  endtask

  task automatic test_nop_stream();
    do_reset();
    imem_ack = 1'b1; imem_rdata = NOP_W; ex_done = 1'b1; use_inc = 1'b1;
    total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL nop_addr0 got=%h exp=0", imem_addr); end
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b1 || brtype !== 4'd1 || pc_sel !== 2'd0 || branch_label !== 16'd0) begin
        bad++;
        $display("FAIL nop_decode%0d got req=%b v=%b bt=%h ps=%h bl=%h exp req=0 v=1 bt=1 ps=0 bl=0",
                 i, imem_req, instr_valid, brtype, pc_sel, branch_label);
      end
      step();
      total++; if (imem_req !== 1'b0 || imem_addr !== 32'(i - 1)) begin
        bad++; $display("FAIL nop_update%0d got req=%b addr=%h exp req=0 addr=%h", i, imem_req, imem_addr, 32'(i - 1));
      end
      step();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'(i)) begin
        bad++; $display("FAIL nop_fetch%0d got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, 32'(i));
      end
    end
  endtask

  task automatic test_branch();
    goto_pc(32'h10);
    total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL br_start got=%h exp=10", imem_addr); end
    imem_rdata = BR_W; next_pc_fix = 32'h16;
    step();
    total++;
    if (brtype !== 4'd1 || branch_label !== 16'h0005 || pc_sel !== 2'd0 || instr !== BR_W) begin
      bad++;
      $display("FAIL br_decode got bt=%h bl=%h ps=%h instr=%h exp bt=1 bl=0005 ps=0 instr=%h",
               brtype, branch_label, pc_sel, instr, BR_W);
    end
    imem_rdata = NOP_W;
    step(); step();
    total++; if (imem_addr !== 32'h16 || imem_req !== 1'b1) begin
      bad++; $display("FAIL br_next got addr=%h req=%b exp addr=16 req=1", imem_addr, imem_req);
    end
  endtask

  task automatic test_jal(input logic [31:0] at_pc, input logic [31:0] exp_link);
    goto_pc(at_pc);
    imem_rdata = JAL_W; next_pc_fix = 32'h40;
    step();
    total++; if (pc_sel !== 2'd1 || jmp_label !== 26'h40 || link_we !== 1'b0) begin
      bad++; $display("FAIL jal_decode got ps=%h jl=%h lw=%b exp ps=1 jl=40 lw=0", pc_sel, jmp_label, link_we);
    end
    imem_rdata = NOP_W;
    step();
    total++; if (link_we !== 1'b1 || link_data !== exp_link || pc !== at_pc) begin
      bad++; $display("FAIL jal_link got lw=%b ld=%h pc=%h exp lw=1 ld=%h pc=%h", link_we, link_data, pc, exp_link, at_pc);
    end
    step();
    total++; if (link_we !== 1'b0 || pc !== 32'h40) begin
      bad++; $display("FAIL jal_after got lw=%b pc=%h exp lw=0 pc=40", link_we, pc);
    end
  endtask

  task automatic test_timeout();
    imem_ack = 1'b0; imem_rdata = NOP_W; ex_done = 1'b0;
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      total++; if (imem_req !== 1'b1 || halted !== 1'b0 || fetch_err !== 1'b0) begin
        bad++; $display("FAIL to_wait%0d got req=%b h=%b fe=%b exp req=1 h=0 fe=0", c, imem_req, halted, fetch_err);
      end
      step();
    end
    total++; if (imem_req !== 1'b0 || halted !== 1'b1 || fetch_err !== 1'b1) begin
      bad++; $display("FAIL to_expire got req=%b h=%b fe=%b exp req=0 h=1 fe=1", imem_req, halted, fetch_err);
    end
    imem_ack = 1'b1; imem_rdata = BR_W; ex_done = 1'b1;
    repeat (3) step();
    total++; if (imem_req !== 1'b0 || halted !== 1'b1 || instr !== 32'h0 || instr_valid !== 1'b0 || fetch_err !== 1'b1) begin
      bad++; $display("FAIL to_late_ack got req=%b h=%b instr=%h v=%b fe=%b exp req=0 h=1 instr=0 v=0 fe=1",
                      imem_req, halted, instr, instr_valid, fetch_err);
    end
  endtask

  task automatic test_ack_at_limit();
    imem_ack = 1'b0; imem_rdata = NOP_W; ex_done = 1'b0;
    do_reset();
    repeat (15) step();
    imem_ack = 1'b1;
    step();
    total++; if (instr_valid !== 1'b1 || halted !== 1'b0 || fetch_err !== 1'b0) begin
      bad++; $display("FAIL ack_limit got v=%b h=%b fe=%b exp v=1 h=0 fe=0", instr_valid, halted, fetch_err);
    end
  endtask

  task automatic test_stall_and_reset();
    int errs;
    goto_pc(32'h30);
    imem_rdata = BR_W; ex_done = 1'b0;
    step();
    imem_rdata = 32'hDEAD_BEEF;
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (pc !== 32'h30 || instr !== BR_W || instr_valid !== 1'b1 || brtype !== 4'd1 ||
          branch_label !== 16'h5 || imem_req !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin
      bad++; $display("FAIL stall_hold got bad_cycles=%0d pc=%h instr=%h exp bad_cycles=0 pc=30 instr=%h", errs, pc, instr, BR_W);
    end
    do_reset();
    total++; if (pc !== 32'h0 || imem_req !== 1'b1 || instr_valid !== 1'b0 || brtype !== 4'd0) begin
      bad++; $display("FAIL stall_reset got pc=%h req=%b v=%b bt=%h exp pc=0 req=1 v=0 bt=0", pc, imem_req, instr_valid, brtype);
    end
  endtask

  task automatic test_halt();
    imem_ack = 1'b1; imem_rdata = HALT_W; ex_done = 1'b0;
    do_reset();
    step();
    total++; if (instr_valid !== 1'b1 || halted !== 1'b0) begin
      bad++; $display("FAIL halt_decode got v=%b h=%b exp v=1 h=0", instr_valid, halted);
    end
    step();
    total++; if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0 || fetch_err !== 1'b0) begin
      bad++; $display("FAIL halt_enter got h=%b v=%b req=%b fe=%b exp h=1 v=0 req=0 fe=0", halted, instr_valid, imem_req, fetch_err);
    end
    for (int c = 0; c < 4; c++) begin
      ex_done = ~ex_done;
      step();
    end
    total++; if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0 || link_we !== 1'b0) begin
      bad++; $display("FAIL halt_stay got h=%b req=%b pc=%h lw=%b exp h=1 req=0 pc=0 lw=0", halted, imem_req, pc, link_we);
    end
  endtask

  initial begin
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; ex_done = 1'b0; use_inc = 1'b1; next_pc_fix = '0;
    test_reset();
    test_nop_stream();
    test_branch();
    test_jal(32'h20, 32'h21);
    test_jal(32'hFFFF_FFFF, 32'h0);
    test_timeout();
    test_ack_at_limit();
    test_stall_and_reset();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
